// File: rtl/camera_pwr_pkg.sv
// Shared state encoding, pin levels per state and 50 MHz default delays
// for the camera power sequencer.
package camera_pwr_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_PWDN_WAIT = 3'd1,
        ST_RST_WAIT  = 3'd2,
        ST_INIT_WAIT = 3'd3,
        ST_ON        = 3'd4,
        ST_SHUTDOWN  = 3'd5
    } state_t;

    localparam int DEF_CNT_W  = 20;
    localparam int DEF_T_PWDN = 262144;
    localparam int DEF_T_RST  = 65535;
    localparam int DEF_T_INIT = 1048575;
    localparam int DEF_T_OFF  = 2500;

    typedef struct packed {
        logic pwnd;
        logic rstn;
        logic init_en;
        logic busy;
    } pin_levels_t;

    function automatic pin_levels_t levels_of(input state_t s);
        pin_levels_t l;
        l = '{pwnd: 1'b1, rstn: 1'b0, init_en: 1'b0, busy: 1'b0};
        case (s)
            ST_PWDN_WAIT: l = '{pwnd: 1'b1, rstn: 1'b0, init_en: 1'b0, busy: 1'b1};
            ST_RST_WAIT:  l = '{pwnd: 1'b0, rstn: 1'b0, init_en: 1'b0, busy: 1'b1};
            ST_INIT_WAIT: l = '{pwnd: 1'b0, rstn: 1'b1, init_en: 1'b0, busy: 1'b1};
            ST_ON:        l = '{pwnd: 1'b0, rstn: 1'b1, init_en: 1'b1, busy: 1'b0};
            ST_SHUTDOWN:  l = '{pwnd: 1'b0, rstn: 1'b0, init_en: 1'b0, busy: 1'b1};
            default:      l = '{pwnd: 1'b1, rstn: 1'b0, init_en: 1'b0, busy: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/camera_power_seq.sv
// Camera sensor power sequencer: timed PWDN/RESETB/init-enable bring-up,
// request-driven shutdown, abort of an in-flight power-up and status outputs.
module camera_power_seq
    import camera_pwr_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int T_PWDN = DEF_T_PWDN,
    parameter int T_RST  = DEF_T_RST,
    parameter int T_INIT = DEF_T_INIT,
    parameter int T_OFF  = DEF_T_OFF
) (
    input  logic               clk_50M,
    input  logic               reset,
    input  logic               power_req,
    output logic               camera_pwnd,
    output logic               camera_rstn,
    output logic               initial_en,
    output logic               up_done,
    output logic               busy,
    output logic [STATE_W-1:0] state_o
);

    localparam longint MAX_T = (64'd1 << CNT_W) - 64'd1;

    if (longint'(T_PWDN) < 1 || longint'(T_PWDN) > MAX_T ||
        longint'(T_RST)  < 1 || longint'(T_RST)  > MAX_T ||
        longint'(T_INIT) < 1 || longint'(T_INIT) > MAX_T ||
        longint'(T_OFF)  < 1 || longint'(T_OFF)  > MAX_T) begin : g_bad_delay
        $error("camera_power_seq: every T_* must lie in 1 .. 2^CNT_W-1");
    end

    // Counter value on the final cycle of each timed state.
    localparam logic [CNT_W-1:0] LAST_PWDN = CNT_W'(T_PWDN - 1);
    localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(T_INIT - 1);
    localparam logic [CNT_W-1:0] LAST_OFF  = CNT_W'(T_OFF - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwnd;
    logic             r_rstn;
    logic             r_init_en;
    logic             r_up_done;
    logic             r_busy;

    state_t           w_state_nxt;
    logic             w_timed;
    logic [CNT_W-1:0] w_cnt_nxt;
    pin_levels_t      w_lvl_nxt;
    logic             w_up_done_nxt;

    // Abort is tested before expiry so a same-edge request drop always wins.
    always_comb begin
        w_state_nxt   = r_state;
        w_timed       = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_lvl_nxt     = levels_of(ST_OFF);
        w_up_done_nxt = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (power_req) w_state_nxt = ST_PWDN_WAIT;
            end
            ST_PWDN_WAIT: begin
                w_timed = 1'b1;
                if (!power_req)              w_state_nxt = ST_OFF;
                else if (r_cnt == LAST_PWDN) w_state_nxt = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                w_timed = 1'b1;
                if (!power_req)             w_state_nxt = ST_SHUTDOWN;
                else if (r_cnt == LAST_RST) w_state_nxt = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                w_timed = 1'b1;
                if (!power_req)              w_state_nxt = ST_SHUTDOWN;
                else if (r_cnt == LAST_INIT) w_state_nxt = ST_ON;
            end
            ST_ON: begin
                if (!power_req) w_state_nxt = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                w_timed = 1'b1;
                if (r_cnt == LAST_OFF) w_state_nxt = ST_OFF;
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase

        if (w_state_nxt != r_state) w_cnt_nxt = '0;
        else if (w_timed)           w_cnt_nxt = r_cnt + 1'b1;

        w_lvl_nxt     = levels_of(w_state_nxt);
        w_up_done_nxt = (r_state == ST_INIT_WAIT) && (w_state_nxt == ST_ON);
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_pwnd    <= 1'b1;
            r_rstn    <= 1'b0;
            r_init_en <= 1'b0;
            r_up_done <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pwnd    <= w_lvl_nxt.pwnd;
            r_rstn    <= w_lvl_nxt.rstn;
            r_init_en <= w_lvl_nxt.init_en;
            r_up_done <= w_up_done_nxt;
            r_busy    <= w_lvl_nxt.busy;
        end
    end

    assign camera_pwnd = r_pwnd;
    assign camera_rstn = r_rstn;
    assign initial_en  = r_init_en;
    assign up_done     = r_up_done;
    assign busy        = r_busy;
    assign state_o     = r_state;

endmodule

// File: tb/tb_camera_power_seq.sv
// Bench for camera_power_seq: directed vector table, async-reset sequence and
// randomized request patterns checked against a phase-time reference model.
module tb_camera_power_seq;

    localparam int TP = 4;
    localparam int TR = 3;
    localparam int TI = 5;
    localparam int TO = 2;

    // Packed view: {state[2:0], pwnd, rstn, initial_en, up_done, busy}
    localparam logic [7:0] E_OFF = {3'd0, 5'b10000};
    localparam logic [7:0] E_PW  = {3'd1, 5'b10001};
    localparam logic [7:0] E_RW  = {3'd2, 5'b00001};
    localparam logic [7:0] E_IW  = {3'd3, 5'b01001};
    localparam logic [7:0] E_ONP = {3'd4, 5'b01110};
    localparam logic [7:0] E_ON  = {3'd4, 5'b01100};
    localparam logic [7:0] E_SD  = {3'd5, 5'b00001};

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       pwnd, rstn, ien, updone, bsy;
    logic [2:0] st;
    logic [7:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    camera_power_seq #(
        .CNT_W (8),
        .T_PWDN(TP),
        .T_RST (TR),
        .T_INIT(TI),
        .T_OFF (TO)
    ) dut (
        .clk_50M    (clk),
        .reset      (rst),
        .power_req  (req),
        .camera_pwnd(pwnd),
        .camera_rstn(rstn),
        .initial_en (ien),
        .up_done    (updone),
        .busy       (bsy),
        .state_o    (st)
    );

    assign outs = {st, pwnd, rstn, ien, updone, bsy};

    typedef struct {
        logic       req;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] e, input int n);
        vec_t v;
        v.req = r;
        v.exp = e;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {st,pwnd,rstn,init_en,up_done,busy} got %b_%b required %b_%b",
                     name, act[7:5], act[4:0], exp[7:5], exp[4:0]);
        end
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            req = tbl[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("%s_row%0d", tag, i), outs, tbl[i].exp);
        end
    endtask

    // Reference model: tracks elapsed time since power-up began and time
    // spent shutting down; pin levels follow from which window the time falls in.
    int   m_mode;   // 0 off, 1 powering up, 2 on, 3 shutting down
    int   m_e;
    int   m_d;
    logic m_pulse;

    function automatic void model_step(input logic r);
        m_pulse = 1'b0;
        case (m_mode)
            0: if (r) begin m_mode = 1; m_e = 0; end
            1: begin
                if (!r) begin
                    if (m_e < TP) m_mode = 0;
                    else begin m_mode = 3; m_d = 0; end
                end else begin
                    m_e++;
                    if (m_e == TP + TR + TI) begin m_mode = 2; m_pulse = 1'b1; end
                end
            end
            2: if (!r) begin m_mode = 3; m_d = 0; end
            default: begin
                m_d++;
                if (m_d == TO) m_mode = 0;
            end
        endcase
    endfunction

    function automatic logic [7:0] model_out();
        case (m_mode)
            0: return E_OFF;
            1: begin
                if (m_e < TP)      return E_PW;
                if (m_e < TP + TR) return E_RW;
                return E_IW;
            end
            2: return m_pulse ? E_ONP : E_ON;
            default: return E_SD;
        endcase
    endfunction

    initial begin
        int len;
        logic cur;

        rst = 1'b1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs, E_OFF);

        // Power-up, shutdown with request held, PWDN abort and restart,
        // abort on RST_WAIT expiry edge, abort at INIT_WAIT 2nd cycle.
        add(1'b1, E_PW, 4);
        add(1'b1, E_RW, 3);
        add(1'b1, E_IW, 5);
        add(1'b1, E_ONP, 1);
        add(1'b1, E_ON, 1);
        add(1'b0, E_SD, 1);
        add(1'b1, E_SD, 1);
        add(1'b1, E_OFF, 1);
        add(1'b1, E_PW, 1);
        add(1'b0, E_OFF, 1);
        add(1'b1, E_PW, 4);
        add(1'b1, E_RW, 2);
        add(1'b0, E_SD, 2);
        add(1'b0, E_OFF, 1);
        add(1'b1, E_PW, 4);
        add(1'b1, E_RW, 3);
        add(1'b1, E_IW, 2);
        add(1'b0, E_SD, 2);
        add(1'b0, E_OFF, 1);

        @(negedge clk);
        rst = 1'b0;
        run_rows(0, tbl.size() - 1, "seq");

        // Async reset between edges while in INIT_WAIT.
        req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_init_wait", outs, E_IW);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_immediate", outs, E_OFF);
        @(posedge clk);
        #1;
        chk("async_rst_held", outs, E_OFF);
        @(negedge clk);
        rst = 1'b0;
        run_rows(0, 13, "repower");

        // Randomized request levels against the model.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_mode  = 0;
        m_e     = 0;
        m_d     = 0;
        m_pulse = 1'b0;
        cur = 1'b0;
        len = 0;
        for (int c = 0; c < 3000; c++) begin
            if (len == 0) begin
                cur = ~cur;
                len = $urandom_range(1, 18);
            end
            len--;
            req = cur;
            model_step(cur);
            @(posedge clk);
            #1;
            chk($sformatf("rand_cyc%0d", c), outs, model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/camera_power_seq.md
Name: camera_power_seq

Overview:
- Parametrised successor to the fixed camera power-on delay chain.
- Drives sensor PWDN and RESETB and the SCCB/register-init enable with cycle-programmable delays.
- Adds a request-driven power-down sequence, abort of an in-flight power-up, re-power without global reset, and status outputs.
- Sits between the board reset logic and the camera register-init block; one instance per sensor.

Parameters:
CNT_W, 20, width of the shared delay counter
T_PWDN, 262144, cycles from power request to PWDN release (~5.2 ms @50 MHz)
T_RST, 65535, cycles from PWDN low to RESETB high (~1.3 ms)
T_INIT, 1048575, cycles from RESETB high to initial_en (~21 ms)
T_OFF, 2500, cycles RESETB held low before PWDN reasserts on shutdown (50 us)
- Every T_* must satisfy 1 <= T_* <= 2^CNT_W - 1 (elaboration-time check).

Ports:
clk_50M  in  1  system clock
reset  in  1  asynchronous, active-high reset
power_req  in  1  level request; 1 = camera powered and configured, 0 = camera off
camera_pwnd  out  1  sensor PWDN, 1 = powered down
camera_rstn  out  1  sensor RESETB, active low
initial_en  out  1  level, 1 while the register-init block may run
up_done  out  1  one-cycle pulse on entry to ON
busy  out  1  1 in any transitional state
state_o  out  3  current state encoding from package

Behaviour:
- Reset (async assert, sync release):
  - state = OFF, counter = 0
  - camera_pwnd = 1, camera_rstn = 0, initial_en = 0, up_done = 0, busy = 0
- All outputs are registered and update on the same edge as the state register; no combinational input-to-output path.
- States and encodings: OFF=0, PWDN_WAIT=1, RST_WAIT=2, INIT_WAIT=3, ON=4, SHUTDOWN=5. Codes 6 and 7 go to OFF on the next edge.
- Output levels per state:
  - OFF and PWDN_WAIT: pwnd 1, rstn 0
  - RST_WAIT: pwnd 0, rstn 0
  - INIT_WAIT: pwnd 0, rstn 1
  - ON: pwnd 0, rstn 1, initial_en 1
  - SHUTDOWN: pwnd 0, rstn 0
  - initial_en is 1 only in ON. busy is 1 in PWDN_WAIT, RST_WAIT, INIT_WAIT and SHUTDOWN.
- Counter: cleared to 0 on every state entry and increments every cycle inside a timed state. A timed state exits on the edge where counter == T_x - 1, so each timed state lasts exactly T_x cycles.
- Transitions:
  - OFF -> PWDN_WAIT on any edge with power_req = 1.
  - PWDN_WAIT -> RST_WAIT after T_PWDN cycles.
  - RST_WAIT -> INIT_WAIT after T_RST cycles.
  - INIT_WAIT -> ON after T_INIT cycles; up_done = 1 for that one cycle.
  - ON -> SHUTDOWN on any edge with power_req = 0.
  - SHUTDOWN -> OFF after T_OFF cycles.
- Abort: power_req = 0 sampled in PWDN_WAIT goes directly to OFF. power_req = 0 sampled in RST_WAIT or INIT_WAIT goes to SHUTDOWN. Abort takes priority over a same-edge timer expiry.
- SHUTDOWN always runs to completion; power_req is ignored there. If power_req = 1 in OFF on the next edge, power-up restarts with full T_PWDN.
- Minimum OFF dwell is 1 cycle.
- Counter must not wrap. Since the T_* bounds hold, it never reaches 2^CNT_W - 1 past its exit compare.
- Reset mid-sequence: immediate return to reset values, including pwnd 1 asynchronously.

Decomposition:
- Package camera_pwr_pkg: state encoding constants/typedef (3-bit), STATE_W = 3, default delay constants for 50 MHz.
- Single module; no sub-module. Counter and FSM live together, since the counter is cleared on state entry.

Test Plan:
- Power-up (T_PWDN=4, T_RST=3, T_INIT=5, T_OFF=2), power_req=1 before edge 0:
  - edge 0: PWDN_WAIT, busy=1
  - edge 4: pwnd 0
  - edge 7: rstn 1
  - edge 12: initial_en 1, up_done pulse for exactly 1 cycle, busy 0, state_o=4
- Shutdown from ON, power_req=0 sampled at edge n:
  - edge n: rstn 0, initial_en 0, pwnd stays 0, busy 1
  - edge n+2: pwnd 1, state_o=0
- Abort in INIT_WAIT at its 2nd cycle: SHUTDOWN on that edge, OFF two edges later. up_done never pulses.
- Abort in PWDN_WAIT, then re-request: direct to OFF with pwnd held 1 throughout. power_req=1 the following cycle restarts; pwnd falls exactly 4 cycles after the new PWDN_WAIT entry.
- Same-edge conflicts:
  - power_req=0 on the RST_WAIT expiry edge -> SHUTDOWN, not INIT_WAIT.
  - power_req=1 throughout SHUTDOWN -> completes to OFF, then PWDN_WAIT next edge.
- Async reset asserted mid-INIT_WAIT between clock edges: pwnd 1, rstn 0, initial_en 0 immediately. After release with power_req=1, the full sequence repeats with identical timing.
